line_fifo_scheduler: RTL and testbench

- Sequences one option FIFO (rows or columns) into parrallel_solver.
- Each line record in the FIFO is a header word (global line index) followed by N option words, where N is the current option count for that line.
- Per word: pops it, presents it to the solver through a valid/ready handshake, and re-queues headers and kept options. Eliminated options are not re-queued.
- Tracks passes over all lines and reports solved, stuck (a full pass with no elimination) or malformed-stream errors.
- Two instances run in parallel: row side and column side.

---
 rtl/line_fifo_scheduler.sv | 167 ++++++++++++++++
 tb/tb_line_fifo_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fifo_scheduler.sv
// Streams header/option words from one side's option FIFO to the line solver, re-queues
// surviving words and classifies each full pass over the lines as progress, stuck or solved.
module line_fifo_scheduler #(
    parameter int WORD_W    = 16,
    parameter int MAX_LINES = 11,
    parameter int CNT_W     = 7,
    parameter int IDX_W     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 num_lines,
    input  logic [IDX_W-1:0]           line_base,
    input  logic [MAX_LINES*CNT_W-1:0] options_amnt,
    input  logic [WORD_W-1:0]          fifo_dout,
    input  logic                       fifo_empty,
    input  logic                       fifo_full,
    output logic                       fifo_rd,
    output logic                       fifo_wr,
    output logic [WORD_W-1:0]          fifo_din,
    output logic [WORD_W-1:0]          solver_option,
    output logic                       solver_valid,
    output logic                       solver_is_hdr,
    input  logic                       solver_ready,
    input  logic                       solver_keep,
    input  logic                       solved,
    output logic                       line_drop,
    output logic [IDX_W-1:0]           drop_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       stuck,
    output logic                       err,
    output logic [7:0]                 pass_count
);

    typedef enum logic [3:0] {
        IDLE, POP_HDR, LAT_HDR, SEND_HDR, POP_OPT, LAT_OPT, SEND_OPT, PASS_END, DONE, STUCK, ERR
    } state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  hdr_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [3:0]        lines_seen_q;
    logic              progress_q;
    logic              kept_q;
    logic [7:0]        pass_q;

    logic [WORD_W-1:0] local_idx;
    logic              hdr_bad;
    logic [CNT_W-1:0]  line_count;
    logic              hs_hdr, hs_opt, last_opt, last_line;

    // Header validation is done on the full word so out-of-range upper bits are caught too.
    assign local_idx = fifo_dout - WORD_W'(line_base);
    assign hdr_bad   = (fifo_dout < WORD_W'(line_base)) || (local_idx >= WORD_W'(num_lines));

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        line_count = '0;
        for (int k = 0; k < MAX_LINES; k++) begin
            if (local_idx == WORD_W'(k)) line_count = options_amnt[k*CNT_W +: CNT_W];
        end
    end

    assign solver_valid  = ((state_q == SEND_HDR) || (state_q == SEND_OPT)) && !fifo_full;
    assign solver_is_hdr = (state_q == SEND_HDR);
    assign solver_option = word_q;
    assign hs_hdr        = (state_q == SEND_HDR) && solver_valid && solver_ready;
    assign hs_opt        = (state_q == SEND_OPT) && solver_valid && solver_ready;
    assign last_opt      = (remaining_q == CNT_W'(1));
    assign last_line     = ((lines_seen_q + 4'd1) == num_lines);

    assign fifo_rd    = ((state_q == POP_HDR) && !solved && !fifo_empty) ||
                        ((state_q == POP_OPT) && !fifo_empty);
    assign fifo_wr    = hs_hdr || (hs_opt && solver_keep);
    assign fifo_din   = word_q;
    assign line_drop  = hs_opt && !solver_keep;
    assign drop_idx   = hdr_q;
    assign busy       = !(state_q inside {IDLE, DONE, STUCK, ERR});
    assign done       = (state_q == DONE);
    assign stuck      = (state_q == STUCK);
    assign err        = (state_q == ERR);
    assign pass_count = pass_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = POP_HDR;
            POP_HDR: begin
                if (solved)           state_d = DONE;
                else if (!fifo_empty) state_d = LAT_HDR;
            end
            LAT_HDR:  state_d = (hdr_bad || line_count == '0) ? ERR : SEND_HDR;
            SEND_HDR: if (hs_hdr) state_d = POP_OPT;
            POP_OPT:  if (!fifo_empty) state_d = LAT_OPT;
            LAT_OPT:  state_d = SEND_OPT;
            SEND_OPT: begin
                if (hs_opt) begin
                    if (!last_opt)                    state_d = POP_OPT;
                    else if (!kept_q && !solver_keep) state_d = ERR;
                    else if (last_line)               state_d = PASS_END;
                    else                              state_d = POP_HDR;
                end
            end
            PASS_END: begin
                if (solved)           state_d = DONE;
                else if (!progress_q) state_d = STUCK;
                else                  state_d = POP_HDR;
            end
            default:  state_d = state_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q       <= '0;
            hdr_q        <= '0;
            remaining_q  <= '0;
            lines_seen_q <= '0;
            progress_q   <= 1'b0;
            kept_q       <= 1'b0;
            pass_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lines_seen_q <= '0;
                        progress_q   <= 1'b0;
                        pass_q       <= '0;
                    end
                end
                LAT_HDR: begin
                    word_q      <= fifo_dout;
                    hdr_q       <= fifo_dout[IDX_W-1:0];
                    remaining_q <= line_count;
                    kept_q      <= 1'b0;
                end
                LAT_OPT: word_q <= fifo_dout;
                SEND_OPT: begin
                    if (hs_opt) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (solver_keep) kept_q     <= 1'b1;
                        else             progress_q <= 1'b1;
                        if (last_opt) lines_seen_q <= lines_seen_q + 4'd1;
                    end
                end
                PASS_END: begin
                    if (!solved && progress_q) begin
                        if (pass_q != 8'hFF) pass_q <= pass_q + 8'd1;
                        progress_q   <= 1'b0;
                        lines_seen_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fifo_scheduler.sv
// Bench for line_fifo_scheduler: a queue-based FIFO, a solver that follows a per-pass script
// of keep/drop decisions, and a stream-level model of what each pass must present and leave behind.
module tb_line_fifo_scheduler;

    localparam int WORD_W    = 16;
    localparam int MAX_LINES = 11;
    localparam int CNT_W     = 7;
    localparam int IDX_W     = 5;
    localparam int BUDGET    = 10000;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic [3:0]                 num_lines;
    logic [IDX_W-1:0]           line_base;
    logic [MAX_LINES*CNT_W-1:0] options_amnt;
    logic [WORD_W-1:0]          fifo_dout;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       fifo_rd;
    logic                       fifo_wr;
    logic [WORD_W-1:0]          fifo_din;
    logic [WORD_W-1:0]          solver_option;
    logic                       solver_valid;
    logic                       solver_is_hdr;
    logic                       solver_ready;
    logic                       solver_keep;
    logic                       solved;
    logic                       line_drop;
    logic [IDX_W-1:0]           drop_idx;
    logic                       busy;
    logic                       done;
    logic                       stuck;
    logic                       err;
    logic [7:0]                 pass_count;

    always #5 clk = ~clk;

    line_fifo_scheduler #(
        .WORD_W(WORD_W), .MAX_LINES(MAX_LINES), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_lines(num_lines), .line_base(line_base),
        .options_amnt(options_amnt), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .solver_option(solver_option), .solver_valid(solver_valid), .solver_is_hdr(solver_is_hdr),
        .solver_ready(solver_ready), .solver_keep(solver_keep), .solved(solved),
        .line_drop(line_drop), .drop_idx(drop_idx), .busy(busy), .done(done), .stuck(stuck),
        .err(err), .pass_count(pass_count)
    );

    typedef struct {
        logic [WORD_W-1:0] word;
        logic              is_hdr;
        logic              keep;
    } ev_t;

    int total = 0;
    int bad   = 0;

    logic [WORD_W-1:0] fq[$];       // the FIFO seen by the DUT
    logic [WORD_W-1:0] mq[$];       // model stream at the start of the current pass
    logic [WORD_W-1:0] next_mq[$];
    int                cnt[MAX_LINES];
    int                next_cnt[MAX_LINES];
    ev_t               evq[$];      // words the solver must see this pass, in order
    bit                script[$];   // forced keep decisions, consumed before random ones
    bit                pass_err;
    int                pass_drops;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_data", {fifo_din, solver_option}, 32'h0);
        check("rst_ctl", {fifo_rd, fifo_wr, solver_valid, solver_is_hdr, line_drop, drop_idx,
                          busy, done, stuck, err, pass_count}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; solved = 1'b0; solver_ready = 1'b0; solver_keep = 1'b0;
        fifo_empty = 1'b1; fifo_full = 1'b0; fifo_dout = '0;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
    endtask

    task automatic clear_model();
        mq.delete();
        script.delete();
        for (int k = 0; k < MAX_LINES; k++) cnt[k] = 0;
    endtask

    task automatic load_counts();
        options_amnt = '0;
        for (int k = 0; k < MAX_LINES; k++) options_amnt[k*CNT_W +: CNT_W] = CNT_W'(cnt[k]);
    endtask

    // Walk the stream line by line, decide every option's fate and derive the next stream.
    task automatic build_pass(input bit allow_all_drop, input int keep_pct);
        int  i, hdr, loc, n, kept;
        bit  keep;
        ev_t e;
        next_mq.delete();
        evq.delete();
        pass_err   = 1'b0;
        pass_drops = 0;
        for (int k = 0; k < MAX_LINES; k++) next_cnt[k] = cnt[k];
        i = 0;
        while (i < mq.size() && !pass_err) begin
            hdr = int'(mq[i]);
            i++;
            loc = hdr - int'(line_base);
            if (hdr < int'(line_base) || loc >= int'(num_lines) || cnt[loc] == 0) begin
                pass_err = 1'b1;
            end else begin
                n = cnt[loc];
                e.word = mq[i-1]; e.is_hdr = 1'b1; e.keep = 1'b1;
                evq.push_back(e);
                next_mq.push_back(mq[i-1]);
                kept = 0;
                for (int j = 0; j < n; j++) begin
                    if (script.size() > 0) keep = script.pop_front();
                    else                   keep = (int'($urandom_range(99)) < keep_pct);
                    if (!allow_all_drop && j == n - 1 && kept == 0) keep = 1'b1;
                    e.word = mq[i]; e.is_hdr = 1'b0; e.keep = keep;
                    evq.push_back(e);
                    if (keep) begin
                        next_mq.push_back(mq[i]);
                        kept++;
                    end else begin
                        pass_drops++;
                    end
                    i++;
                end
                next_cnt[loc] = kept;
                if (kept == 0) pass_err = 1'b1;
            end
        end
    endtask

    // exp_term: 0 running, 1 done, 2 stuck, 3 err
    task automatic run(input int solve_pass, input bit allow_all_drop, input int keep_pct,
                       input int stall_pct, input int full_pct, input bit rst_at_opt);
        int                pass, exp_pc, exp_term, full_left, ready_left;
        bit                p_rd, p_wr, pend, fin, hs;
        logic [WORD_W-1:0] p_din, held;
        logic [IDX_W-1:0]  cur_hdr;
        ev_t               e;
        pass = 0; exp_pc = 0; exp_term = 0; full_left = 0; ready_left = 0;
        p_rd = 1'b0; p_wr = 1'b0; pend = 1'b0; fin = 1'b0; p_din = '0; held = '0; cur_hdr = '0;
        fq = mq;
        load_counts();
        build_pass(allow_all_drop, keep_pct);
        if (evq.size() == 0) exp_term = 3;
        for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
            @(negedge clk);
            if (p_rd && fq.size() > 0) fifo_dout = fq.pop_front();
            if (p_wr) fq.push_back(p_din);
            start = (cyc == 0);
            if (full_left == 0 && int'($urandom_range(99)) < full_pct) full_left = 4;
            fifo_full = (full_left > 0);
            if (full_left > 0) full_left--;
            if (ready_left == 0 && int'($urandom_range(99)) < stall_pct) ready_left = 3;
            solver_ready = (ready_left == 0);
            if (ready_left > 0) ready_left--;
            fifo_empty  = (fq.size() == 0);
            solver_keep = (evq.size() > 0) ? evq[0].keep : 1'b0;
            #1;
            if (rst_at_opt && solver_valid && !solver_is_hdr) begin
                solver_ready = 1'b0;
                #1 rst = 1'b1;
                #1 check_reset_outputs();
                return;
            end
            hs    = solver_valid && solver_ready;
            p_rd  = fifo_rd;
            p_wr  = fifo_wr;
            p_din = fifo_din;
            if (fifo_rd)   check("rd_nonempty", fifo_empty, 0);
            if (fifo_full) check("valid_while_full", solver_valid, 0);
            if (pend)      check("option_stable", solver_option, held);
            if (hs) begin
                pend = 1'b0;
                check("busy", busy, 1);
                check("word_expected", evq.size() != 0, 1);
                if (evq.size() != 0) begin
                    e = evq.pop_front();
                    check("word", solver_option, e.word);
                    check("is_hdr", solver_is_hdr, e.is_hdr);
                    check("push", fifo_wr, e.keep);
                    if (e.is_hdr) begin
                        cur_hdr = e.word[IDX_W-1:0];
                        check("pass_count", pass_count, exp_pc);
                    end
                    check("drop", line_drop, !e.is_hdr && !e.keep);
                    if (line_drop) check("drop_idx", drop_idx, cur_hdr);
                    if (evq.size() == 0) begin
                        for (int k = 0; k < MAX_LINES; k++) cnt[k] = next_cnt[k];
                        mq = next_mq;
                        load_counts();
                        if (pass_err) exp_term = 3;
                        else if (pass == solve_pass) begin
                            solved   = 1'b1;
                            exp_term = 1;
                        end else if (pass_drops == 0) exp_term = 2;
                        else begin
                            exp_pc = (exp_pc < 255) ? exp_pc + 1 : 255;
                            pass++;
                            build_pass(allow_all_drop, keep_pct);
                            if (evq.size() == 0) exp_term = 3;
                        end
                    end
                end
            end else begin
                check("push_idle", fifo_wr, 0);
                check("drop_idle", line_drop, 0);
                if (solver_valid) begin
                    pend = 1'b1;
                    held = solver_option;
                end
            end
            if (done || stuck || err) fin = 1'b1;
        end
        check("finished", fin, 1);
        check("flags", {done, stuck, err}, {exp_term == 1, exp_term == 2, exp_term == 3});
        check("busy_end", busy, 0);
        check("pass_count_end", pass_count, exp_pc);
        if (exp_term != 3) begin
            check("fifo_size", fq.size(), mq.size());
            for (int i = 0; i < fq.size() && i < mq.size(); i++) check("fifo_word", fq[i], mq[i]);
        end
        solved = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        check("sticky", {done, stuck, err, busy}, {exp_term == 1, exp_term == 2, exp_term == 3, 1'b0});
    endtask

    task automatic gen_random(input int max_opt);
        int order[MAX_LINES];
        int nl, j, tmp;
        clear_model();
        nl        = int'($urandom_range(1, MAX_LINES));
        num_lines = 4'(nl);
        line_base = IDX_W'($urandom_range(0, 32 - nl));
        for (int k = 0; k < MAX_LINES; k++) order[k] = k;
        for (int k = nl - 1; k > 0; k--) begin
            j        = int'($urandom_range(0, k));
            tmp      = order[k];
            order[k] = order[j];
            order[j] = tmp;
        end
        for (int k = 0; k < nl; k++) begin
            cnt[order[k]] = int'($urandom_range(1, max_opt));
            mq.push_back(WORD_W'(int'(line_base) + order[k]));
            for (int m = 0; m < cnt[order[k]]; m++) mq.push_back(WORD_W'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; solved = 1'b0; solver_ready = 1'b0; solver_keep = 1'b0;
        fifo_empty = 1'b1; fifo_full = 1'b0; fifo_dout = '0;
        num_lines = 4'd1; line_base = '0; options_amnt = '0;

        // Single line kept, solved after pass 0.
        do_reset();
        clear_model();
        num_lines = 4'd1; line_base = '0; cnt[0] = 1;
        mq.push_back(16'h0000); mq.push_back(16'h07FF);
        run(0, 1'b0, 100, 0, 0, 1'b0);

        // Two lines, B dropped in pass 0, nothing dropped in pass 1.
        do_reset();
        clear_model();
        num_lines = 4'd2; line_base = '0; cnt[0] = 2; cnt[1] = 1;
        mq.push_back(16'h0000); mq.push_back(16'h00A1); mq.push_back(16'h00B2);
        mq.push_back(16'h0001); mq.push_back(16'h00C3);
        script.push_back(1'b1); script.push_back(1'b0); script.push_back(1'b1);
        run(-1, 1'b0, 100, 0, 0, 1'b0);

        // Column side with a header below its base.
        do_reset();
        clear_model();
        num_lines = 4'd4; line_base = 5'd11;
        for (int k = 0; k < 4; k++) cnt[k] = 1;
        mq.push_back(16'h0005); mq.push_back(16'h1234);
        run(-1, 1'b0, 100, 0, 0, 1'b0);

        // Header whose line has no options left.
        do_reset();
        clear_model();
        num_lines = 4'd2; line_base = 5'd3; cnt[0] = 1; cnt[1] = 0;
        mq.push_back(16'h0003); mq.push_back(16'h5A5A); mq.push_back(16'h0004);
        run(-1, 1'b0, 100, 0, 0, 1'b0);

        // Every option of a line eliminated.
        do_reset();
        clear_model();
        num_lines = 4'd1; line_base = 5'd7; cnt[0] = 2;
        mq.push_back(16'h0007); mq.push_back(16'hBEEF); mq.push_back(16'hCAFE);
        script.push_back(1'b0); script.push_back(1'b0);
        run(-1, 1'b1, 100, 0, 0, 1'b0);

        // Heavy FIFO-full and solver-stall bursts.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            gen_random(3);
            run(int'($urandom_range(0, 3)) - 1, 1'b0, 70, 30, 30, 1'b0);
        end

        // Reset in the middle of an option handshake, then a normal run.
        do_reset();
        clear_model();
        num_lines = 4'd1; line_base = '0; cnt[0] = 2;
        mq.push_back(16'h0000); mq.push_back(16'h1111); mq.push_back(16'h2222);
        run(-1, 1'b0, 100, 0, 0, 1'b1);
        @(negedge clk) rst = 1'b0;
        clear_model();
        num_lines = 4'd1; line_base = '0; cnt[0] = 2;
        mq.push_back(16'h0000); mq.push_back(16'h1111); mq.push_back(16'h2222);
        script.push_back(1'b0); script.push_back(1'b1);
        run(-1, 1'b0, 100, 0, 0, 1'b0);

        // Randomized streams.
        for (int r = 0; r < 12; r++) begin
            do_reset();
            gen_random(3);
            run(int'($urandom_range(0, 5)) - 1, 1'b0, int'($urandom_range(55, 90)),
                int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
